// File: rtl/mesi_bus_pkg.sv
// Shared types for the MESI snooping bus arbiter: bus operations, FSM states,
// default cache count and the per-cache operation priority helper.
package mesi_bus_pkg;

  localparam int NUM_CACHES_DEF = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RD   = 2'd1,
    RDX  = 2'd2,
    UPGR = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    WB    = 3'd2,
    MEM   = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  // A cache raising several requests at once gets its strongest one serviced.
  function automatic bus_op_t pick_op(input logic rd, input logic rdx, input logic upgr);
    bus_op_t op;
    if (rdx) begin
      op = RDX;
    end else if (upgr) begin
      op = UPGR;
    end else if (rd) begin
      op = RD;
    end else begin
      op = NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/mesi_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// modulo N; returns both a one-hot grant and the winner index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    int c;
    c     = 0;
    gnt   = {N{1'b0}};
    idx   = {IW{1'b0}};
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!valid && req[IW'(c)]) begin
        valid        = 1'b1;
        idx          = IW'(c);
        gnt[IW'(c)]  = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snooping bus arbiter for MESI caches: one transaction at a time through
// snoop broadcast, optional writeback or memory read, then a grant pulse.
module mesi_bus_arbiter
  import mesi_bus_pkg::*;
#(
  parameter int NUM_CACHES  = NUM_CACHES_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [NUM_CACHES-1:0] req_rd,
  input  logic [NUM_CACHES-1:0] req_rdx,
  input  logic [NUM_CACHES-1:0] req_upgr,
  input  logic [NUM_CACHES-1:0] hit_in,
  input  logic [NUM_CACHES-1:0] flush_in,
  output logic [NUM_CACHES-1:0] snoop_rd,
  output logic [NUM_CACHES-1:0] snoop_rdx,
  output logic [NUM_CACHES-1:0] snoop_upgr,
  output logic [NUM_CACHES-1:0] gnt,
  output logic [NUM_CACHES-1:0] c_out,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [NUM_CACHES-1:0] NO_CACHE = {NUM_CACHES{1'b0}};

  arb_state_t            state_r;
  bus_op_t               op_r;
  logic [IW-1:0]         rr_ptr_r;
  logic [IW-1:0]         win_idx_r;
  logic                  shared_r;
  logic                  dirty_r;
  logic [CW-1:0]         wait_cnt_r;

  logic [NUM_CACHES-1:0] any_req_s;
  logic [NUM_CACHES-1:0] arb_gnt_s;
  logic [IW-1:0]         arb_idx_s;
  logic                  arb_valid_s;
  bus_op_t               arb_op_s;
  logic [NUM_CACHES-1:0] win_mask_s;
  logic [NUM_CACHES-1:0] cout_s;
  logic                  shared_s;
  logic                  dirty_s;
  logic [IW-1:0]         rr_next_s;

  assign any_req_s = req_rd | req_rdx | req_upgr;

  rr_arbiter #(.N(NUM_CACHES), .IW(IW)) u_rr (
    .req   (any_req_s),
    .ptr   (rr_ptr_r),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  assign arb_op_s   = pick_op(req_rd[arb_idx_s], req_rdx[arb_idx_s], req_upgr[arb_idx_s]);
  assign win_mask_s = NUM_CACHES'(1) << win_idx_r;
  // The winner's own snoop response is meaningless for its own request.
  assign shared_s   = |(hit_in & ~win_mask_s);
  assign dirty_s    = |(flush_in & ~win_mask_s);
  assign cout_s     = (op_r == RD && shared_r) ? win_mask_s : NO_CACHE;
  assign rr_next_s  = (win_idx_r == IW'(NUM_CACHES - 1)) ? {IW{1'b0}} : win_idx_r + IW'(1);

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r    <= IDLE;
      op_r       <= NONE;
      rr_ptr_r   <= {IW{1'b0}};
      win_idx_r  <= {IW{1'b0}};
      shared_r   <= 1'b0;
      dirty_r    <= 1'b0;
      wait_cnt_r <= {CW{1'b0}};
      snoop_rd   <= NO_CACHE;
      snoop_rdx  <= NO_CACHE;
      snoop_upgr <= NO_CACHE;
      gnt        <= NO_CACHE;
      c_out      <= NO_CACHE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arb_valid_s) begin
            state_r    <= SNOOP;
            win_idx_r  <= arb_idx_s;
            op_r       <= arb_op_s;
            busy       <= 1'b1;
            snoop_rd   <= (arb_op_s == RD)   ? ~arb_gnt_s : NO_CACHE;
            snoop_rdx  <= (arb_op_s == RDX)  ? ~arb_gnt_s : NO_CACHE;
            snoop_upgr <= (arb_op_s == UPGR) ? ~arb_gnt_s : NO_CACHE;
          end else begin
            state_r <= IDLE;
          end
        end
        SNOOP: begin
          snoop_rd   <= NO_CACHE;
          snoop_rdx  <= NO_CACHE;
          snoop_upgr <= NO_CACHE;
          shared_r   <= shared_s;
          dirty_r    <= dirty_s;
          wait_cnt_r <= {CW{1'b0}};
          if (dirty_s) begin
            state_r <= WB;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end else if (op_r == UPGR) begin
            state_r <= DONE;
            gnt     <= win_mask_s;
            c_out   <= NO_CACHE;
          end else begin
            state_r <= MEM;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
          end
        end
        WB, MEM: begin
          // A flushing cache supplies the data, so a writeback always finishes the transaction.
          if (mem_ack) begin
            state_r <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            gnt     <= win_mask_s;
            c_out   <= cout_s;
          end else if (wait_cnt_r == CW'(MEM_TIMEOUT - 1)) begin
            state_r <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            gnt     <= win_mask_s;
            c_out   <= cout_s;
            err     <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
            mem_we     <= dirty_r;
          end
        end
        DONE: begin
          state_r    <= IDLE;
          gnt        <= NO_CACHE;
          c_out      <= NO_CACHE;
          err        <= 1'b0;
          busy       <= 1'b0;
          wait_cnt_r <= {CW{1'b0}};
          rr_ptr_r   <= rr_next_s;
        end
        default: begin
          state_r    <= IDLE;
          snoop_rd   <= NO_CACHE;
          snoop_rdx  <= NO_CACHE;
          snoop_upgr <= NO_CACHE;
          gnt        <= NO_CACHE;
          c_out      <= NO_CACHE;
          mem_req    <= 1'b0;
          mem_we     <= 1'b0;
          busy       <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Randomized self-checking bench for mesi_bus_arbiter against a transaction-level
// model of the round-robin/priority/snoop rules, plus directed corner cases.
module tb_mesi_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic [N-1:0] req_rd = '0, req_rdx = '0, req_upgr = '0;
  logic [N-1:0] hit_in = '0, flush_in = '0;
  logic         mem_ack = 1'b0;
  logic [N-1:0] snoop_rd, snoop_rdx, snoop_upgr, gnt, c_out;
  logic         mem_req, mem_we, busy, err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_rr = 0;
  int gnt_cyc = 0;

  mesi_bus_arbiter #(.NUM_CACHES(N), .MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req_rd     (req_rd),
    .req_rdx    (req_rdx),
    .req_upgr   (req_upgr),
    .hit_in     (hit_in),
    .flush_in   (flush_in),
    .snoop_rd   (snoop_rd),
    .snoop_rdx  (snoop_rdx),
    .snoop_upgr (snoop_upgr),
    .gnt        (gnt),
    .c_out      (c_out),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {8'h00, snoop_rd, snoop_rdx, snoop_upgr, gnt, c_out, mem_req, mem_we, busy, err}, 32'h0);
  endtask

  // Model: winner is the first cache at or after model_rr (mod N) with any request;
  // op codes 1=RD 2=RDX 3=UPGR, RDX strongest, RD weakest.
  task automatic pick(output int w, output int op);
    int c;
    w  = -1;
    op = 0;
    for (int i = 0; i < N; i++) begin
      c = (model_rr + i) % N;
      if (w < 0 && (req_rd[c] || req_rdx[c] || req_upgr[c])) begin
        w  = c;
        op = req_rdx[c] ? 2 : (req_upgr[c] ? 3 : 1);
      end
    end
  endtask

  // Called at a negedge while the arbiter is idle with requests already driven.
  task automatic run_txn(input logic [N-1:0] hit, input logic [N-1:0] flush,
                         input int ack_dly, input bit withhold, input bit noise);
    int w, op;
    logic [N-1:0] m, rest, exp_c;
    logic sh, dt, mem_phase;
    pick(w, op);
    if (w < 0) begin
      step();
      check_eq("idle_stay", {busy, mem_req, gnt}, 32'h0);
      return;
    end
    m    = 4'b0001 << w;
    rest = ~m;
    step();
    check_eq("snoop_vec", {snoop_rd, snoop_rdx, snoop_upgr},
             {(op == 1) ? rest : 4'h0, (op == 2) ? rest : 4'h0, (op == 3) ? rest : 4'h0});
    check_eq("snoop_ctl", {busy, gnt, c_out, mem_req, err}, {1'b1, 4'h0, 4'h0, 1'b0, 1'b0});
    hit_in   = hit;
    flush_in = flush;
    mem_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noise) begin
      req_rd   = req_rd   | (4'($urandom) & 4'($urandom) & 4'($urandom));
      req_rdx  = req_rdx  | (4'($urandom) & 4'($urandom) & 4'($urandom));
      req_upgr = req_upgr | (4'($urandom) & 4'($urandom) & 4'($urandom));
    end
    sh = |(hit & rest);
    dt = |(flush & rest);
    mem_phase = dt || (op != 3);
    step();
    hit_in   = '0;
    flush_in = '0;
    mem_ack  = 1'b0;
    if (mem_phase) begin
      for (int n = 1; n <= TO; n++) begin
        check_eq("mem_phase", {busy, mem_req, mem_we, gnt, err, snoop_rd},
                 {1'b1, 1'b1, dt, 4'h0, 1'b0, 4'h0});
        if (!withhold && n == ack_dly + 1) begin
          mem_ack = 1'b1;
          step();
          mem_ack = 1'b0;
          break;
        end
        step();
      end
    end
    exp_c = (op == 1 && sh) ? m : 4'h0;
    check_eq("gnt", gnt, m);
    check_eq("c_out", c_out, exp_c);
    check_eq("err", err, withhold && mem_phase);
    check_eq("done_ctl", {busy, mem_req, mem_we}, 3'b100);
    gnt_cyc = cyc;
    if (op == 1) req_rd[w] = 1'b0;
    else if (op == 2) req_rdx[w] = 1'b0;
    else req_upgr[w] = 1'b0;
    step();
    model_rr = (w + 1) % N;
    check_eq("back_idle", {busy, gnt, c_out, err, mem_req, mem_we}, 32'h0);
  endtask

  initial begin
    int prev;
    logic [N-1:0] h, f;
    bit wh;

    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rstb = 1'b1;
    step();
    check_all_zero("idle_after_reset");

    // Cache0 read, nobody shares it: memory read, no shared indication.
    req_rd = 4'b0001;
    run_txn(4'h0, 4'h0, 1, 1'b0, 1'b0);
    // Cache1 read, cache2 holds the line: shared back to the winner.
    req_rd = 4'b0010;
    run_txn(4'b0100, 4'h0, 0, 1'b0, 1'b0);
    // Cache2 read-exclusive, cache3 dirty: writeback only.
    req_rdx = 4'b0100;
    run_txn(4'h0, 4'b1000, 2, 1'b0, 1'b0);
    // Cache3 read with memory never answering: timeout error.
    req_rd = 4'b1000;
    run_txn(4'h0, 4'h0, 0, 1'b1, 1'b0);
    check_eq("rr_after_wrap", model_rr, 0);

    // Four simultaneous upgrades are granted in order, three cycles apart.
    req_upgr = 4'b1111;
    run_txn(4'h0, 4'h0, 0, 1'b0, 1'b0);
    for (int k = 1; k < N; k++) begin
      prev = gnt_cyc;
      run_txn(4'h0, 4'h0, 0, 1'b0, 1'b0);
      check_eq("upgr_gap", gnt_cyc - prev, 3);
    end

    // Winner's own hit/flush must be ignored.
    req_rd = 4'b0001;
    run_txn(4'b0001, 4'b0001, 0, 1'b0, 1'b0);

    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        req_rd   = req_rd   | 4'($urandom_range(0, 15));
        req_rdx  = req_rdx  | (4'($urandom) & 4'($urandom));
        req_upgr = req_upgr | (4'($urandom) & 4'($urandom));
      end
      h  = 4'($urandom);
      f  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      wh = ($urandom_range(0, 49) == 0);
      run_txn(h, f, $urandom_range(0, 4), wh, 1'b1);
    end

    // Drain pending requests, then reset in the middle of a memory read.
    req_rd   = '0;
    req_rdx  = '0;
    req_upgr = '0;
    step();
    model_rr = 0;
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    req_rd = 4'b0010;
    run_txn(4'h0, 4'h0, 0, 1'b0, 1'b0);
    req_rd = 4'b1010;
    step();
    check_eq("pre_reset_snoop", snoop_rd, 4'b0111);
    step();
    check_eq("pre_reset_mem", mem_req, 1'b1);
    rstb = 1'b0;
    #1;
    check_all_zero("async_reset");
    step();
    check_all_zero("held_reset");
    rstb = 1'b1;
    model_rr = 0;
    run_txn(4'h0, 4'h0, 0, 1'b0, 1'b0);
    check_eq("restart_rr", model_rr, 2);
    run_txn(4'h0, 4'h0, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mesi_bus_arbiter.md
MESI_BUS_ARBITER -- requirements
Module: mesi_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CACHES, default 4: number of attached cache MESI controllers.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255: max cycles waiting for mem_ack before abort.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rstb  input  1  reset; asynchronous, active-low.
REQ-005 req_rd  input  NUM_CACHES  per-cache BusRd request, held high until that cache's gnt.
REQ-006 req_rdx  input  NUM_CACHES  per-cache BusRdX request, held high until gnt.
REQ-007 req_upgr  input  NUM_CACHES  per-cache BusUpgr request, held high until gnt.
REQ-008 hit_in  input  NUM_CACHES  per-cache snoop response: line valid (S/E/M) in that cache.
REQ-009 flush_in  input  NUM_CACHES  per-cache snoop response: cache is flushing a dirty line.
REQ-010 snoop_rd, snoop_rdx, snoop_upgr  output  NUM_CACHES each  broadcast snooped operation to every cache except the winner.
REQ-011 gnt  output  NUM_CACHES  one-hot, single-cycle completion pulse to the winner.
REQ-012 c_out  output  NUM_CACHES  shared indication to the winner; valid only while its gnt bit is high.
REQ-013 mem_req, mem_we  output  1 each  memory read (mem_we=0) or writeback (mem_we=1) request.
REQ-014 mem_ack  input  1  one-cycle memory completion.
REQ-015 busy  output  1  high in every state except IDLE; err  output  1  one-cycle pulse on timeout.

Function
REQ-016 SHALL implement FSM states IDLE, SNOOP, WB, MEM, DONE.
REQ-017 IDLE: if any request bit set, SHALL select winner round-robin starting at rr_ptr, latch winner index and op, go to SNOOP next cycle; otherwise remain in IDLE.
REQ-018 When one cache asserts more than one request bit, op priority SHALL be RDX > UPGR > RD.
REQ-019 SNOOP lasts exactly 1 cycle: SHALL assert the latched op on snoop_* for all non-winner bits; winner's snoop bit SHALL be 0.
REQ-020 SNOOP: SHALL latch shared = OR(hit_in & ~winner_mask) and dirty = OR(flush_in & ~winner_mask); winner's own hit/flush SHALL be ignored.
REQ-021 After SNOOP: dirty -> WB; else op UPGR -> DONE; else (RD/RDX) -> MEM.
REQ-022 WB: SHALL hold mem_req=1, mem_we=1 until mem_ack; then RD/RDX -> DONE (data supplied by flush), UPGR -> DONE.
REQ-023 MEM: SHALL hold mem_req=1, mem_we=0 until mem_ack, then go to DONE.
REQ-024 DONE lasts 1 cycle: gnt[winner]=1, c_out[winner]=shared for RD and 0 for RDX/UPGR; rr_ptr SHALL become (winner+1) mod NUM_CACHES; next state IDLE.
REQ-025 Minimum latency, request to gnt: UPGR 3 cycles (IDLE, SNOOP, DONE); RD/RDX with mem_ack on first MEM cycle: 4 cycles.
REQ-026 A wait counter SHALL count cycles in WB/MEM; on reaching MEM_TIMEOUT, SHALL pulse err, drop mem_req, go to DONE with gnt asserted.
REQ-027 mem_ack outside WB/MEM SHALL be ignored.
REQ-028 Requests arriving while busy SHALL stay pending and SHALL NOT disturb the current transaction.
REQ-029 A pending UPGR whose cache is invalidated by another winner's snoop SHALL still be serviced as issued; conversion to RDX is the requesting cache's responsibility.
REQ-030 rr_ptr wraps NUM_CACHES-1 -> 0; winner search wraps modulo NUM_CACHES.

Reset
REQ-031 rstb low SHALL asynchronously force IDLE, rr_ptr=0, wait counter=0, latched winner/op/shared/dirty=0.
REQ-032 During and after reset, all outputs SHALL be 0 (gnt, c_out, snoop_*, mem_req, mem_we, busy, err), including reset mid-transaction.

Structure
REQ-033 Package mesi_bus_pkg SHALL hold bus_op_t (NONE, RD, RDX, UPGR), arb_state_t, and the NUM_CACHES default.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, rr_ptr in; one-hot grant and index out; combinational).

Verification
REQ-035 Cache0 req_rd, no hits, mem_ack 1 cycle after mem_req -> gnt=0001, c_out[0]=0, snoop_rd=1110 for one cycle.
REQ-036 Cache1 req_rd, hit_in=0100 during SNOOP -> c_out[1]=1 with gnt=0010.
REQ-037 Cache2 req_rdx, flush_in=1000 during SNOOP -> mem_we=1 writeback, then gnt=0100, no mem_we=0 read, snoop_rdx=1011.
REQ-038 All four req_upgr simultaneously, rr_ptr=0 -> grants in order 0,1,2,3, each 3 cycles after the previous IDLE.
REQ-039 req_rd from cache3, mem_ack withheld -> err pulse after 255 MEM cycles, gnt=1000, back to IDLE.
REQ-040 rstb low during MEM -> all outputs 0 immediately (asynchronous); after release, pending request restarts from IDLE with rr_ptr=0.
